// File: rtl/uci_host_pkg.sv
// Shared chess/UCI definitions: move encoding, FSM state enums and the
// move <-> ASCII helpers used by the UCI host and its reply parser.
package uci_host_pkg;

    localparam int unsigned COORD_W = 3;
    localparam int unsigned IDX_W   = 5;

    localparam logic [7:0] CHAR_NL = 8'h0A;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_A  = 8'h61;
    localparam logic [7:0] CHAR_H  = 8'h68;
    localparam logic [7:0] CHAR_1  = 8'h31;
    localparam logic [7:0] CHAR_8  = 8'h38;

    typedef enum logic [2:0] {
        SPECIAL_NONE       = 3'd0,
        SPECIAL_PROMOTE_N  = 3'd1,
        SPECIAL_PROMOTE_B  = 3'd2,
        SPECIAL_PROMOTE_R  = 3'd3,
        SPECIAL_PROMOTE_Q  = 3'd4,
        SPECIAL_CASTLE     = 3'd5,
        SPECIAL_EN_PASSANT = 3'd6
    } special_t;

    typedef struct packed {
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
    } square_t;

    typedef struct packed {
        square_t  src;
        square_t  dst;
        special_t special;
    } move_t;

    typedef struct packed {
        logic  ok;
        move_t mv;
    } parse_t;

    typedef enum logic [2:0] {
        IDLE, TX_POS, TX_MOVE, TX_SEP, TX_NL, TX_GO, WAIT_REPLY
    } tx_state_t;

    typedef enum logic [1:0] {
        LINE_START, MATCH, TOKEN, SKIP
    } rx_state_t;

    // Byte 0 of each string is the first character on the wire.
    localparam logic [0:22][7:0] POS_STR      = "position startpos moves";
    localparam logic [0:8][7:0]  BESTMOVE_STR = "bestmove ";
    localparam logic [IDX_W-1:0] POS_SHORT_LAST = 5'd16;
    localparam logic [IDX_W-1:0] POS_LONG_LAST  = 5'd22;
    localparam logic [3:0]       BESTMOVE_LAST  = 4'd8;

    function automatic logic is_promo(input special_t s);
        is_promo = (s == SPECIAL_PROMOTE_N) || (s == SPECIAL_PROMOTE_B) ||
                   (s == SPECIAL_PROMOTE_R) || (s == SPECIAL_PROMOTE_Q);
    endfunction

    function automatic logic [7:0] promo_char(input special_t s);
        case (s)
            SPECIAL_PROMOTE_N: promo_char = 8'h6E;
            SPECIAL_PROMOTE_B: promo_char = 8'h62;
            SPECIAL_PROMOTE_R: promo_char = 8'h72;
            SPECIAL_PROMOTE_Q: promo_char = 8'h71;
            default:           promo_char = 8'h00;
        endcase
    endfunction

    // Character idx (0..4) of a move in long algebraic notation.
    function automatic logic [7:0] move_char(input move_t m, input logic [2:0] idx);
        case (idx)
            3'd0:    move_char = CHAR_A + 8'(m.src.col);
            3'd1:    move_char = CHAR_1 + 8'(m.src.row);
            3'd2:    move_char = CHAR_A + 8'(m.dst.col);
            3'd3:    move_char = CHAR_1 + 8'(m.dst.row);
            3'd4:    move_char = promo_char(m.special);
            default: move_char = 8'h00;
        endcase
    endfunction

    function automatic logic is_col(input logic [7:0] b);
        is_col = (b >= CHAR_A) && (b <= CHAR_H);
    endfunction

    function automatic logic is_row(input logic [7:0] b);
        is_row = (b >= CHAR_1) && (b <= CHAR_8);
    endfunction

    // Decode a collected token; tok[0] is the first received byte.
    function automatic parse_t parse_token(input logic [4:0][7:0] tok, input logic [2:0] len);
        parse_t r;
        logic   coords_ok;
        coords_ok     = is_col(tok[0]) && is_row(tok[1]) && is_col(tok[2]) && is_row(tok[3]);
        r.mv.src.col  = 3'(tok[0] - CHAR_A);
        r.mv.src.row  = 3'(tok[1] - CHAR_1);
        r.mv.dst.col  = 3'(tok[2] - CHAR_A);
        r.mv.dst.row  = 3'(tok[3] - CHAR_1);
        r.mv.special  = SPECIAL_NONE;
        r.ok          = 1'b0;
        if (len == 3'd4) begin
            r.ok = coords_ok;
        end else if (len == 3'd5) begin
            r.ok = coords_ok;
            case (tok[4])
                8'h6E:   r.mv.special = SPECIAL_PROMOTE_N;
                8'h62:   r.mv.special = SPECIAL_PROMOTE_B;
                8'h72:   r.mv.special = SPECIAL_PROMOTE_R;
                8'h71:   r.mv.special = SPECIAL_PROMOTE_Q;
                default: r.ok = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/uci_host_parser.sv
// Line-oriented parser for engine replies: recognises "bestmove <tok>" and
// reports the decoded token combinationally in the cycle its terminator arrives.
module uci_reply_parser
    import uci_host_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] char_in,
    input  logic       char_in_valid,
    output logic       done_c,
    output logic       ok_c,
    output move_t      move_c
);

    rx_state_t       rs_q, rs_d;
    logic [3:0]      midx_q, midx_d;
    logic [2:0]      len_q, len_d;
    logic [4:0][7:0] tok_q, tok_d;
    parse_t          pr;
    logic            is_nl;
    logic            is_term;

    always_comb begin
        rs_d    = rs_q;
        midx_d  = midx_q;
        len_d   = len_q;
        tok_d   = tok_q;
        done_c  = 1'b0;
        ok_c    = 1'b0;
        move_c  = '0;
        pr      = parse_token(tok_q, len_q);
        is_nl   = (char_in == CHAR_NL);
        is_term = is_nl || (char_in == CHAR_SP);
        if (char_in_valid) begin
            case (rs_q)
                LINE_START: begin
                    if (char_in == BESTMOVE_STR[0]) begin
                        rs_d   = MATCH;
                        midx_d = 4'd1;
                    end else if (!is_nl) begin
                        rs_d = SKIP;
                    end
                end
                MATCH: begin
                    if (char_in == BESTMOVE_STR[midx_q]) begin
                        if (midx_q == BESTMOVE_LAST) begin
                            rs_d  = TOKEN;
                            len_d = 3'd0;
                        end else begin
                            midx_d = midx_q + 4'd1;
                        end
                    end else begin
                        rs_d = is_nl ? LINE_START : SKIP;
                    end
                end
                TOKEN: begin
                    if (is_term) begin
                        done_c = 1'b1;
                        ok_c   = pr.ok;
                        move_c = pr.mv;
                        rs_d   = is_nl ? LINE_START : SKIP;
                    end else begin
                        // Length saturates at 6 so over-long tokens stay malformed.
                        if (len_q < 3'd5) tok_d[len_q] = char_in;
                        if (len_q < 3'd6) len_d = len_q + 3'd1;
                    end
                end
                SKIP: begin
                    if (is_nl) rs_d = LINE_START;
                end
                default: rs_d = LINE_START;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rs_q   <= LINE_START;
            midx_q <= '0;
            len_q  <= '0;
            tok_q  <= '0;
        end else begin
            rs_q   <= rs_d;
            midx_q <= midx_d;
            len_q  <= len_d;
            tok_q  <= tok_d;
        end
    end

endmodule

// File: rtl/uci_host.sv
// UCI initiator: keeps the game's move history, streams "position ... go" to
// the engine on request and returns the engine's bestmove.
module uci_host
    import uci_host_pkg::*;
#(
    parameter int unsigned MAX_MOVES = 256
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           new_game,
    input  move_t                          move_in,
    input  logic                           move_in_valid,
    output logic                           move_in_ready,
    input  logic                           go_in,
    output logic                           busy,
    output logic [7:0]                     char_out,
    output logic                           char_out_valid,
    input  logic                           char_out_ready,
    input  logic [7:0]                     char_in,
    input  logic                           char_in_valid,
    output logic                           char_in_ready,
    output move_t                          best_move_out,
    output logic                           best_move_valid,
    output logic                           bad_reply,
    output logic [$clog2(MAX_MOVES+1)-1:0] move_count
);

    localparam int unsigned CNT_W = $clog2(MAX_MOVES + 1);
    localparam int unsigned AW    = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

    tx_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] ply_q, ply_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       char_q, char_d;
    logic             char_valid_q, char_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic             bmv_q, bmv_d;
    logic             bad_q, bad_d;
    move_t            best_q, best_d;
    move_t            hist_rd_q;
    move_t            hist_mem [MAX_MOVES];
    logic             hist_we;
    logic             can_load;
    logic             move_last;
    logic             rx_done_c;
    logic             rx_ok_c;
    move_t            rx_move_c;

    uci_reply_parser u_parser (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .char_in       (char_in),
        .char_in_valid (char_in_valid),
        .done_c        (rx_done_c),
        .ok_c          (rx_ok_c),
        .move_c        (rx_move_c)
    );

    // Transmit FSM: a new byte is loaded whenever the output register is free or draining.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ply_d        = ply_q;
        count_d      = count_q;
        char_d       = char_q;
        char_valid_d = char_valid_q && !char_out_ready;
        bmv_d        = 1'b0;
        bad_d        = 1'b0;
        best_d       = best_q;
        hist_we      = 1'b0;
        can_load     = !char_valid_q || char_out_ready;
        move_last    = (idx_q == 5'd4) || ((idx_q == 5'd3) && !is_promo(hist_rd_q.special));
        case (state_q)
            IDLE: begin
                ply_d = '0;
                if (new_game) begin
                    count_d = '0;
                end else if (move_in_valid && in_ready_q) begin
                    hist_we = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
                if (go_in) begin
                    state_d = TX_POS;
                    idx_d   = '0;
                    if (can_load) begin
                        char_d       = POS_STR[0];
                        char_valid_d = 1'b1;
                        idx_d        = 5'd1;
                    end
                end
            end
            TX_POS: begin
                if (can_load) begin
                    char_d       = POS_STR[idx_q];
                    char_valid_d = 1'b1;
                    idx_d        = idx_q + 5'd1;
                    if ((idx_q == POS_SHORT_LAST) && (count_q == '0)) begin
                        state_d = TX_NL;
                    end else if (idx_q == POS_LONG_LAST) begin
                        state_d = TX_SEP;
                    end
                end
            end
            TX_SEP: begin
                // Ply address advanced on the previous move's last byte, so
                // the synchronous read lands during this separator.
                if (can_load) begin
                    char_d       = CHAR_SP;
                    char_valid_d = 1'b1;
                    idx_d        = '0;
                    state_d      = TX_MOVE;
                end
            end
            TX_MOVE: begin
                if (can_load) begin
                    char_d       = move_char(hist_rd_q, idx_q[2:0]);
                    char_valid_d = 1'b1;
                    idx_d        = idx_q + 5'd1;
                    if (move_last) begin
                        ply_d   = ply_q + CNT_W'(1);
                        state_d = (ply_d < count_q) ? TX_SEP : TX_NL;
                    end
                end
            end
            TX_NL: begin
                if (can_load) begin
                    char_d       = CHAR_NL;
                    char_valid_d = 1'b1;
                    idx_d        = '0;
                    state_d      = TX_GO;
                end
            end
            TX_GO: begin
                if (can_load) begin
                    char_valid_d = 1'b1;
                    idx_d        = idx_q + 5'd1;
                    case (idx_q)
                        5'd0:    char_d = 8'h67;
                        5'd1:    char_d = 8'h6F;
                        default: char_d = CHAR_NL;
                    endcase
                    if (idx_q == 5'd2) state_d = WAIT_REPLY;
                end
            end
            WAIT_REPLY: begin
                if (rx_done_c) begin
                    state_d = IDLE;
                    bmv_d   = rx_ok_c;
                    bad_d   = !rx_ok_c;
                    if (rx_ok_c) best_d = rx_move_c;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE) && (count_d < MAX_CNT);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ply_q        <= '0;
            count_q      <= '0;
            char_q       <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            bmv_q        <= 1'b0;
            bad_q        <= 1'b0;
            best_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ply_q        <= ply_d;
            count_q      <= count_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            bmv_q        <= bmv_d;
            bad_q        <= bad_d;
            best_q       <= best_d;
        end
    end

    // History RAM with synchronous read.
    always_ff @(posedge clk_in) begin
        if (hist_we) hist_mem[count_q[AW-1:0]] <= move_in;
        hist_rd_q <= hist_mem[ply_q[AW-1:0]];
    end

    assign move_in_ready   = in_ready_q;
    assign busy            = busy_q;
    assign char_out        = char_q;
    assign char_out_valid  = char_valid_q;
    assign char_in_ready   = 1'b1;
    assign best_move_out   = best_q;
    assign best_move_valid = bmv_q;
    assign bad_reply       = bad_q;
    assign move_count      = count_q;

endmodule
